// File: rtl/ex_stage_mdu.sv
// ex_stage_mdu: execute stage with single-cycle ALU, branch-target adder,
// ALU-source and destination-register muxes, an iterative radix-2
// multiply/divide unit, and the EX/MEM pipeline register.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid / in_ready   ID/EX handshake (in_ready is combinational)
//   flush                 kills the instruction currently in EX
//   mem_stall             EX/MEM register holds while asserted
//   wb_ctl, m_ctl         control fields passed through to EX/MEM
//   alusrc, regdst        operand-B mux and destination-register mux selects
//   op                    operation code (0-9 ALU, 10-16 MDU, others ADD)
//   npc, rdata1, rdata2,
//   imm, rd_a, rd_b       operands and candidate destination registers
//   out_valid ... dest_reg  registered EX/MEM outputs
//   busy                  MDU state machine is not idle
//
// Build option: define EX_DIV_EN to include the iterative divider. Without
// it, DIV/DIVU/REM/REMU retire in one cycle with an all-ones result.
//
// state  | meaning
// IDLE   | no MDU op in flight; single-cycle ops retire directly
// MUL    | one shift-add step per cycle, cnt_q counts remaining steps
// DIV    | one restoring-subtract step per cycle
// DONE   | MDU result ready; written to EX/MEM when mem_stall drops

module ex_stage_mdu #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  input  logic                  mem_stall,
  input  logic [1:0]            wb_ctl,
  input  logic [2:0]            m_ctl,
  input  logic                  alusrc,
  input  logic                  regdst,
  input  logic [4:0]            op,
  input  logic [XLEN-1:0]       npc,
  input  logic [XLEN-1:0]       rdata1,
  input  logic [XLEN-1:0]       rdata2,
  input  logic [XLEN-1:0]       imm,
  input  logic [REG_ADDR_W-1:0] rd_a,
  input  logic [REG_ADDR_W-1:0] rd_b,
  output logic                  out_valid,
  output logic [1:0]            wb_ctlout,
  output logic                  branch,
  output logic                  memread,
  output logic                  memwrite,
  output logic [XLEN-1:0]       branch_target,
  output logic                  zero,
  output logic [XLEN-1:0]       alu_result,
  output logic [XLEN-1:0]       rdata2out,
  output logic [REG_ADDR_W-1:0] dest_reg,
  output logic                  busy
);

  localparam int SH_W  = $clog2(XLEN);
  localparam int CNT_W = $clog2(XLEN) + 1;

  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_SLT   = 5'd5;
  localparam logic [4:0] OP_SLTU  = 5'd6;
  localparam logic [4:0] OP_SLL   = 5'd7;
  localparam logic [4:0] OP_SRL   = 5'd8;
  localparam logic [4:0] OP_SRA   = 5'd9;
  localparam logic [4:0] OP_MUL   = 5'd10;
  localparam logic [4:0] OP_MULH  = 5'd11;
  localparam logic [4:0] OP_MULHU = 5'd12;
  localparam logic [4:0] OP_DIV   = 5'd13;
  localparam logic [4:0] OP_DIVU  = 5'd14;
  localparam logic [4:0] OP_REM   = 5'd15;
  localparam logic [4:0] OP_REMU  = 5'd16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_nxt;

  logic [XLEN-1:0]  operand_b;
  logic [SH_W-1:0]  shamt;
  logic [XLEN-1:0]  alu_out;
  logic [XLEN-1:0]  mdu_out;
  logic [XLEN-1:0]  ex_result;
  logic             is_mul_op, is_div_op, is_mdu_op, signed_op;
  logic             a_neg, b_neg;
  logic [XLEN-1:0]  a_mag, b_mag;
  logic             mdu_start;
  logic             prod_neg;

  logic [4:0]       op_q;
  logic             a_neg_q, b_neg_q;
  logic [XLEN-1:0]  hi_q, lo_q, mcand_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN:0]    mul_sum;

  // Decode
  always_comb begin
    is_mul_op = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHU);
    is_div_op = (op >= OP_DIV) && (op <= OP_REMU);
`ifdef EX_DIV_EN
    is_mdu_op = is_mul_op || is_div_op;
    signed_op = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
`else
    is_mdu_op = is_mul_op;
    signed_op = (op == OP_MULH);
`endif
  end

  assign operand_b = alusrc ? imm : rdata2;
  assign shamt     = operand_b[SH_W-1:0];

  // Single-cycle ALU
  always_comb begin
    alu_out = rdata1 + operand_b;
    case (op)
      OP_SUB:  alu_out = rdata1 - operand_b;
      OP_AND:  alu_out = rdata1 & operand_b;
      OP_OR:   alu_out = rdata1 | operand_b;
      OP_XOR:  alu_out = rdata1 ^ operand_b;
      OP_SLT:  alu_out = {{(XLEN-1){1'b0}}, ($signed(rdata1) < $signed(operand_b))};
      OP_SLTU: alu_out = {{(XLEN-1){1'b0}}, (rdata1 < operand_b)};
      OP_SLL:  alu_out = rdata1 << shamt;
      OP_SRL:  alu_out = rdata1 >> shamt;
      OP_SRA:  alu_out = $unsigned($signed(rdata1) >>> shamt);
      default: ;
    endcase
`ifndef EX_DIV_EN
    if (is_div_op) alu_out = '1;
`endif
  end

  // The iterative core works on magnitudes; signs are reapplied at the end.
  assign a_neg     = signed_op & rdata1[XLEN-1];
  assign b_neg     = signed_op & operand_b[XLEN-1];
  assign a_mag     = a_neg ? -rdata1 : rdata1;
  assign b_mag     = b_neg ? -operand_b : operand_b;
  assign mdu_start = (state_q == S_IDLE) && in_valid && !flush && is_mdu_op;

  // {hi_q, lo_q} is the product shift register: lo_q starts as the
  // multiplier and is shifted out while product bits are shifted in.
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);

`ifdef EX_DIV_EN
  // Divide: hi_q is the partial remainder, lo_q the dividend being shifted
  // out while quotient bits are shifted in, mcand_q the divisor.
  logic            b_zero_q;
  logic [XLEN:0]   div_shift;
  logic [XLEN-1:0] div_diff;
  logic            div_ge;

  assign div_shift = {hi_q, lo_q[XLEN-1]};
  assign div_ge    = div_shift >= {1'b0, mcand_q};
  // Only used when div_ge, where the difference is below the divisor.
  assign div_diff  = div_shift[XLEN-1:0] - mcand_q;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_nxt;
  end

  // Next state and handshake
  always_comb begin
    state_nxt = state_q;
    in_ready  = 1'b0;
    busy      = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (mdu_start) state_nxt = is_mul_op ? S_MUL : S_DIV;
        in_ready = !mem_stall && in_valid && !is_mdu_op;
      end
      S_MUL, S_DIV: begin
        if (cnt_q == CNT_W'(1)) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (!mem_stall) state_nxt = S_IDLE;
        in_ready = !mem_stall && in_valid;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (flush) begin
      state_nxt = S_IDLE;
      in_ready  = 1'b1;
    end
  end

  // MDU datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
`ifdef EX_DIV_EN
      b_zero_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mdu_start) begin
            op_q    <= op;
            a_neg_q <= a_neg;
            b_neg_q <= b_neg;
            hi_q    <= '0;
            cnt_q   <= CNT_W'(XLEN);
`ifdef EX_DIV_EN
            b_zero_q <= (operand_b == '0);
            lo_q     <= is_div_op ? a_mag : b_mag;
            mcand_q  <= is_div_op ? b_mag : a_mag;
`else
            lo_q    <= b_mag;
            mcand_q <= a_mag;
`endif
          end
        end
        S_MUL: begin
          hi_q  <= mul_sum[XLEN:1];
          lo_q  <= {mul_sum[0], lo_q[XLEN-1:1]};
          cnt_q <= cnt_q - CNT_W'(1);
        end
`ifdef EX_DIV_EN
        S_DIV: begin
          hi_q  <= div_ge ? div_diff : div_shift[XLEN-1:0];
          lo_q  <= {lo_q[XLEN-2:0], div_ge};
          cnt_q <= cnt_q - CNT_W'(1);
        end
`endif
        default: ;
      endcase
    end
  end

  // Sign fixup and result select. The high half of -{hi,lo} is ~hi plus
  // the carry out of ~lo + 1, which only occurs when lo is zero.
  always_comb begin
    prod_neg = a_neg_q ^ b_neg_q;
    mdu_out  = hi_q;
    case (op_q)
      OP_MUL:  mdu_out = lo_q;
      OP_MULH: mdu_out = prod_neg ? (~hi_q + {{(XLEN-1){1'b0}}, (lo_q == '0)}) : hi_q;
`ifdef EX_DIV_EN
      OP_DIV, OP_DIVU: mdu_out = b_zero_q ? '1 : (prod_neg ? -lo_q : lo_q);
      OP_REM, OP_REMU: mdu_out = a_neg_q ? -hi_q : hi_q;
`endif
      default: ;
    endcase
  end

  assign ex_result = (state_q == S_DONE) ? mdu_out : alu_out;

  // EX/MEM register; bubbles still load the data fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid     <= 1'b0;
      wb_ctlout     <= '0;
      branch        <= 1'b0;
      memread       <= 1'b0;
      memwrite      <= 1'b0;
      branch_target <= '0;
      zero          <= 1'b0;
      alu_result    <= '0;
      rdata2out     <= '0;
      dest_reg      <= '0;
    end else if (!mem_stall) begin
      out_valid                   <= in_ready && in_valid && !flush;
      wb_ctlout                   <= wb_ctl;
      {branch, memread, memwrite} <= m_ctl;
      branch_target               <= npc + imm;
      zero                        <= (ex_result == '0);
      alu_result                  <= ex_result;
      rdata2out                   <= rdata2;
      dest_reg                    <= regdst ? rd_b : rd_a;
    end
  end

endmodule

// File: tb/tb_ex_stage_mdu.sv
module tb_ex_stage_mdu;

  localparam int XLEN = 32;
  localparam int RW   = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid, in_ready, flush, mem_stall;
  logic [1:0]      wb_ctl;
  logic [2:0]      m_ctl;
  logic            alusrc, regdst;
  logic [4:0]      op;
  logic [XLEN-1:0] npc, rdata1, rdata2, imm;
  logic [RW-1:0]   rd_a, rd_b;
  logic            out_valid;
  logic [1:0]      wb_ctlout;
  logic            branch, memread, memwrite;
  logic [XLEN-1:0] branch_target;
  logic            zero;
  logic [XLEN-1:0] alu_result, rdata2out;
  logic [RW-1:0]   dest_reg;
  logic            busy;

  ex_stage_mdu #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .mem_stall(mem_stall), .wb_ctl(wb_ctl), .m_ctl(m_ctl),
    .alusrc(alusrc), .regdst(regdst), .op(op), .npc(npc), .rdata1(rdata1),
    .rdata2(rdata2), .imm(imm), .rd_a(rd_a), .rd_b(rd_b),
    .out_valid(out_valid), .wb_ctlout(wb_ctlout), .branch(branch),
    .memread(memread), .memwrite(memwrite), .branch_target(branch_target),
    .zero(zero), .alu_result(alu_result), .rdata2out(rdata2out),
    .dest_reg(dest_reg), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic [31:0] bt;
    logic [4:0]  dst;
    logic [1:0]  wb;
    logic [2:0]  mc;
    logic [31:0] rd2;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic stall_rand = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // Reference results from the RISC-V arithmetic rules.
  function automatic logic [31:0] ref_result(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] pu, ps;
    longint      sa, sb;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = a;
    ib = b;
    pu = {32'd0, a} * {32'd0, b};
    ps = sa * sb;
    case (o)
      5'd1:  return a - b;
      5'd2:  return a & b;
      5'd3:  return a | b;
      5'd4:  return a ^ b;
      5'd5:  return (ia < ib) ? 32'd1 : 32'd0;
      5'd6:  return (a < b) ? 32'd1 : 32'd0;
      5'd7:  return a << b[4:0];
      5'd8:  return a >> b[4:0];
      5'd9:  return 32'($signed(a) >>> b[4:0]);
      5'd10: return pu[31:0];
      5'd11: return ps[63:32];
      5'd12: return pu[63:32];
`ifdef EX_DIV_EN
      5'd13: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(ia / ib);
      end
      5'd14: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd15: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      5'd16: return (b == 0) ? a : a % b;
`else
      5'd13, 5'd14, 5'd15, 5'd16: return 32'hFFFF_FFFF;
`endif
      default: return a + b;
    endcase
  endfunction

  function automatic exp_t make_exp();
    exp_t        e;
    logic [31:0] ob;
    ob    = alusrc ? imm : rdata2;
    e.res  = ref_result(op, rdata1, ob);
    e.zero = (e.res == 32'd0);
    e.bt   = npc + imm;
    e.dst  = regdst ? rd_b : rd_a;
    e.wb   = wb_ctl;
    e.mc   = m_ctl;
    e.rd2  = rdata2;
    return e;
  endfunction

  task automatic drive(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b2,
                       input logic [31:0] im, input logic [31:0] pc, input logic asrc);
    op       = o;
    rdata1   = a;
    rdata2   = b2;
    imm      = im;
    npc      = pc;
    alusrc   = asrc;
    regdst   = 1'($urandom_range(0, 1));
    rd_a     = 5'($urandom);
    rd_b     = 5'($urandom);
    wb_ctl   = 2'($urandom);
    m_ctl    = 3'($urandom);
    in_valid = 1'b1;
  endtask

  // Call just after a falling edge. Holds the instruction until it is
  // consumed; returns how many cycles in_ready was low beforehand.
  task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b2,
                       input logic [31:0] im, input logic [31:0] pc, input logic asrc,
                       output int waits);
    logic rdy;
    bit   done;
    drive(o, a, b2, im, pc, asrc);
    waits = 0;
    done  = 0;
    while (!done) begin
      #1;
      rdy = in_ready;
      if (rdy) sb_q.push_back(make_exp());
      @(posedge clk);
      if (rdy) done = 1;
      else waits++;
      if (!done && waits > 200) begin
        n_tests++;
        n_fail++;
        $display("FAIL issue_timeout: actual in_ready low %0d cycles required <= 200", waits);
        done = 1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every EX/MEM load carrying a valid instruction is checked.
  initial begin
    logic ld;
    exp_t e;
    forever begin
      @(posedge clk);
      ld = !mem_stall && !reset;
      #1;
      if (ld && out_valid) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: actual out_valid with result %0h required no output", alu_result);
        end else begin
          e = sb_q.pop_front();
          check("alu_result", 64'(alu_result), 64'(e.res));
          check("zero", 64'(zero), 64'(e.zero));
          check("branch_target", 64'(branch_target), 64'(e.bt));
          check("ctl_fields", 64'({dest_reg, wb_ctlout, branch, memread, memwrite, rdata2out}),
                64'({e.dst, e.wb, e.mc, e.rd2}));
        end
      end
    end
  end

  always @(negedge clk) if (stall_rand) mem_stall = ($urandom_range(0, 3) == 0);

  initial begin
    #600000;
    $display("FAIL watchdog: actual simulation still running required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int mdu_wait;
`ifdef EX_DIV_EN
    mdu_wait = 33;
`else
    mdu_wait = 0;
`endif
    reset = 1'b1; in_valid = 0; flush = 0; mem_stall = 0; wb_ctl = 0; m_ctl = 0;
    alusrc = 0; regdst = 0; op = 0; npc = 0; rdata1 = 0; rdata2 = 0; imm = 0;
    rd_a = 0; rd_b = 0;
    repeat (2) @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_alu_result", 64'(alu_result), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_target", 64'(branch_target), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases
    issue(5'd0, 32'd5, 32'd0, 32'hFFFF_FFFD, 32'h100, 1'b1, w);
    check("add_wait", 64'(w), 64'd0);
    issue(5'd0, 32'd5, 32'd9, 32'h20, 32'h100, 1'b1, w);
    issue(5'd11, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'h40, 1'b0, w);
    check("mulh_not_ready_cycles", 64'(w), 64'd33);
    issue(5'd12, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'h44, 1'b0, w);
    check("mulhu_not_ready_cycles", 64'(w), 64'd33);
    issue(5'd13, 32'd7, 32'd0, 32'd0, 32'h48, 1'b0, w);
    check("div0_wait", 64'(w), 64'(mdu_wait));
    issue(5'd15, 32'd7, 32'd0, 32'd0, 32'h4C, 1'b0, w);
    issue(5'd13, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h50, 1'b0, w);
    issue(5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h54, 1'b0, w);
    issue(5'd14, 32'd100, 32'd7, 32'd0, 32'h58, 1'b0, w);
    issue(5'd16, 32'd100, 32'd7, 32'd0, 32'h5C, 1'b0, w);
    repeat (2) @(negedge clk);

    // mem_stall held while the MDU sits in DONE
    drive(5'd10, 32'd3, 32'd4, 32'd0, 32'h200, 1'b0);
    @(posedge clk);
    @(negedge clk);
    mem_stall = 1'b1;
    repeat (32) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("hold_busy", 64'(busy), 64'd1);
      check("hold_not_ready", 64'(in_ready), 64'd0);
      check("hold_no_output", 64'(out_valid), 64'd0);
      @(negedge clk);
    end
    mem_stall = 1'b0;
    sb_q.push_back(make_exp());
    #1;
    check("hold_release_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("hold_release_idle", 64'(busy), 64'd0);
    @(negedge clk);

    // flush while MUL is mid-way (count = 10)
    drive(5'd10, 32'd123, 32'd456, 32'd0, 32'h300, 1'b0);
    @(posedge clk);
    repeat (22) @(posedge clk);
    @(negedge clk);
    check("flush_pre_busy", 64'(busy), 64'd1);
    flush = 1'b1;
    #1;
    check("flush_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_bubble", 64'(out_valid), 64'd0);
    issue(5'd0, 32'd11, 32'd22, 32'd0, 32'h310, 1'b0, w);
    check("flush_next_add_wait", 64'(w), 64'd0);

    // reset in the middle of a multiply
    drive(5'd11, 32'd77, 32'd88, 32'h10, 32'h400, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("pre_reset_busy", 64'(busy), 64'd1);
    check("pre_reset_target", 64'(branch_target), 64'h410);
    #2;
    reset = 1'b1;
    #1;
    check("mid_reset_busy", 64'(busy), 64'd0);
    check("mid_reset_result", 64'(alu_result), 64'd0);
    check("mid_reset_target", 64'(branch_target), 64'd0);
    check("mid_reset_valid", 64'(out_valid), 64'd0);
    in_valid = 1'b0;
    sb_q.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Randomised stream with random back-pressure
    stall_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      issue(5'($urandom_range(0, 31)), rnd_val(), rnd_val(), rnd_val(), $urandom,
            1'($urandom_range(0, 1)), w);
    end
    stall_rand = 1'b0;
    @(negedge clk);
    mem_stall = 1'b0;
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
